// File: rtl/instruction_cache.sv
// ---------------------------------------------------------------------------
// instruction_cache
//
// Direct-mapped, read-only instruction cache between the CPU fetch stage and
// a 128-bit block instruction memory. Hits are served combinationally in the
// request cycle. A miss stalls the CPU (BUSYWAIT), issues a registered block
// read to memory, fills the line and then resumes.
//
// Optional feature macro: ICACHE_PERF_CNT_EN adds HIT_COUNT / MISS_COUNT.
//
// Ports:
//   CLOCK         sole clock, all state updates on posedge
//   RESET         synchronous active-high reset
//   READ          CPU fetch request
//   ADDRESS       CPU byte address (tag | index | word offset | byte)
//   INSTRUCTION   fetched word, zero unless READ=1 and BUSYWAIT=0
//   BUSYWAIT      CPU stall
//   MEM_READ      registered block-read request to memory
//   MEM_ADDRESS   registered block address (latched ADDRESS[31:4])
//   MEM_READDATA  returned 128-bit block
//   MEM_BUSYWAIT  memory busy, low when MEM_READDATA is valid
//   HIT_COUNT     (ICACHE_PERF_CNT_EN) IDLE hit cycles
//   MISS_COUNT    (ICACHE_PERF_CNT_EN) started block reads
// ---------------------------------------------------------------------------
module instruction_cache #(
   parameter int INDEX_BITS = 3
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         READ,
   input  logic [31:0]  ADDRESS,
   output logic [31:0]  INSTRUCTION,
   output logic         BUSYWAIT,
   output logic         MEM_READ,
   output logic [27:0]  MEM_ADDRESS,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]  HIT_COUNT,
   output logic [31:0]  MISS_COUNT
`endif
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 28 - INDEX_BITS;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_READ = 2'd1,
      ST_UPDATE   = 2'd2
   } state_t;

   state_t state, next_state;

   logic [LINES-1:0]    valid_bits;
   logic [TAG_BITS-1:0] tag_array  [LINES];
   logic [127:0]        data_array [LINES];

   logic [INDEX_BITS-1:0] cur_index;
   logic [TAG_BITS-1:0]   cur_tag;
   logic [1:0]            cur_offset;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0]   fill_tag;
   logic                  hit;
   logic                  fill_en;
   logic                  mem_read_d;
   logic [27:0]           mem_address_d;
   logic [127:0]          cur_line;
   logic [1:0]            unused_byte_bits;

   // Address decode. The fill targets the latched block address, never the
   // live CPU address, so a misbehaving CPU cannot corrupt another line.
   assign cur_offset       = ADDRESS[3:2];
   assign cur_index        = ADDRESS[3+INDEX_BITS:4];
   assign cur_tag          = ADDRESS[31:4+INDEX_BITS];
   assign fill_index       = MEM_ADDRESS[INDEX_BITS-1:0];
   assign fill_tag         = MEM_ADDRESS[27:INDEX_BITS];
   assign unused_byte_bits = ADDRESS[1:0];
   assign cur_line         = data_array[cur_index];

   // Hit only counts in IDLE; during a fill the CPU is stalled regardless.
   assign hit = READ && valid_bits[cur_index] &&
                (tag_array[cur_index] == cur_tag) && (state == ST_IDLE);

   // Stall while a miss is pending or being serviced.
   assign BUSYWAIT = ((state == ST_IDLE) && READ && !hit) ||
                     (state == ST_MEM_READ) || (state == ST_UPDATE);

   // Word select from the resident line; zero whenever no word is delivered.
   always_comb begin
      INSTRUCTION = 32'h0;
      if (hit) begin
         case (cur_offset)
            2'd0:    INSTRUCTION = cur_line[31:0];
            2'd1:    INSTRUCTION = cur_line[63:32];
            2'd2:    INSTRUCTION = cur_line[95:64];
            default: INSTRUCTION = cur_line[127:96];
         endcase
      end
   end

   // State register; reset wins over any transition in the same edge.
   always_ff @(posedge CLOCK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next state plus the next values of the registered memory request.
   // MEM_READ/MEM_ADDRESS hold their value unless a transition changes them.
   always_comb begin
      next_state    = state;
      mem_read_d    = MEM_READ;
      mem_address_d = MEM_ADDRESS;
      fill_en       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (READ && !hit) begin
               next_state    = ST_MEM_READ;
               mem_read_d    = 1'b1;
               mem_address_d = ADDRESS[31:4];
            end
         end
         ST_MEM_READ: begin
            if (!MEM_BUSYWAIT) begin
               fill_en    = 1'b1;
               mem_read_d = 1'b0;
               next_state = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
            mem_read_d = 1'b0;
         end
      endcase
   end

   // Memory request registers and valid bits. Reset abandons any fill in
   // flight, so the target line simply stays invalid.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         MEM_READ    <= 1'b0;
         MEM_ADDRESS <= 28'h0;
         valid_bits  <= '0;
      end else begin
         MEM_READ    <= mem_read_d;
         MEM_ADDRESS <= mem_address_d;
         if (fill_en) valid_bits[fill_index] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; the valid bit guards them.
   always_ff @(posedge CLOCK) begin
      if (fill_en) begin
         tag_array[fill_index]  <= fill_tag;
         data_array[fill_index] <= MEM_READDATA;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   // Performance counters; both wrap naturally at 2^32.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         HIT_COUNT  <= 32'h0;
         MISS_COUNT <= 32'h0;
      end else begin
         if (hit) HIT_COUNT <= HIT_COUNT + 32'd1;
         if ((state == ST_IDLE) && (next_state == ST_MEM_READ))
            MISS_COUNT <= MISS_COUNT + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// ---------------------------------------------------------------------------
// tb_instruction_cache
//
// Scoreboard bench for instruction_cache. Fetch stimulus pushes the expected
// instruction word (and, for misses, the expected block address) into queues;
// a monitor on the falling clock edge pops and compares whenever the cache
// delivers a word or starts a block read. A small memory model answers block
// reads with a programmable latency L.
// ---------------------------------------------------------------------------
module tb_instruction_cache;

   logic         CLOCK;
   logic         RESET;
   logic         READ;
   logic [31:0]  ADDRESS;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]  HIT_COUNT;
   logic [31:0]  MISS_COUNT;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0] expInstrQ [$];
   logic [27:0] expAddrQ  [$];

   int memLatency = 0;
   int memCount   = 0;

   instruction_cache #(.INDEX_BITS(3)) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .READ         (READ),
      .ADDRESS      (ADDRESS),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .HIT_COUNT    (HIT_COUNT),
      .MISS_COUNT   (MISS_COUNT)
`endif
   );

   // Free-running clock.
   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // Memory contents for the blocks the test touches; {w3,w2,w1,w0}.
   function automatic logic [127:0] memBlock(input logic [27:0] blk);
      case (blk)
         28'h0000000: memBlock = {32'h00418213, 32'h00310193, 32'h00208113, 32'h8F108093};
         28'h0000001: memBlock = {32'h10000004, 32'h10000003, 32'h10000002, 32'h10000001};
         28'h0000008: memBlock = {32'h0DD00213, 32'h0CC00193, 32'h0BB00113, 32'h0AA00093};
         28'h000001F: memBlock = {32'h1F0F0004, 32'h1F0F0003, 32'h1F0F0002, 32'h1F0F0001};
         default:     memBlock = {4{32'hDEADBEEF}};
      endcase
   endfunction

   // Memory model: busy for memLatency cycles starting with the first cycle
   // MEM_READ is high; the block for MEM_ADDRESS is always presented.
   always @(posedge CLOCK) begin
      if (!MEM_READ) memCount <= 0;
      else           memCount <= memCount + 1;
   end
   assign MEM_BUSYWAIT = MEM_READ && (memCount < memLatency);
   assign MEM_READDATA = memBlock(MEM_ADDRESS);

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: compares delivered words and block-read starts against the
   // scoreboard queues, and checks MEM_ADDRESS stays put while MEM_READ is up.
   logic        prevMemRead = 1'b0;
   logic [27:0] heldAddr    = 28'h0;
   always @(negedge CLOCK) begin
      if (!RESET && READ && !BUSYWAIT) begin
         if (expInstrQ.size() == 0) begin
            checkOutput("unexpected instruction", INSTRUCTION, 32'hxxxxxxxx);
         end else begin
            checkOutput("instruction", INSTRUCTION, expInstrQ.pop_front());
         end
      end
      if (MEM_READ && !prevMemRead) begin
         if (expAddrQ.size() == 0) begin
            checkOutput("unexpected mem read", {4'h0, MEM_ADDRESS}, 32'hxxxxxxxx);
         end else begin
            checkOutput("mem address", {4'h0, MEM_ADDRESS}, {4'h0, expAddrQ.pop_front()});
         end
         heldAddr = MEM_ADDRESS;
      end else if (MEM_READ) begin
         checkOutput("mem address stable", {4'h0, MEM_ADDRESS}, {4'h0, heldAddr});
      end
      prevMemRead = MEM_READ;
   end

   // One fetch: present the address, count stall cycles and MEM_READ cycles,
   // then consume the delivering cycle. Called just after a rising edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expWord,
                                input bit isMiss, input int latency);
      int stall;
      int memCycles;
      stall     = 0;
      memCycles = 0;
      memLatency = latency;
      if (isMiss) expAddrQ.push_back(addr[31:4]);
      expInstrQ.push_back(expWord);
      READ    = 1'b1;
      ADDRESS = addr;
      forever begin
         @(negedge CLOCK);
         if (MEM_READ) memCycles++;
         if (!BUSYWAIT) break;
         stall++;
         if (stall > 200) begin
            checkOutput("stall timeout", 32'(stall), 32'(latency + 3));
            break;
         end
      end
      checkOutput($sformatf("stall cycles @%08h", addr), 32'(stall),
                  isMiss ? 32'(latency + 3) : 32'd0);
      checkOutput($sformatf("mem read cycles @%08h", addr), 32'(memCycles),
                  isMiss ? 32'(latency + 1) : 32'd0);
      @(posedge CLOCK);
      #1;
   endtask

   // Global safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL global timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      RESET   = 1'b1;
      READ    = 1'b0;
      ADDRESS = 32'h0;
      repeat (3) @(posedge CLOCK);
      #1;
      RESET = 1'b0;
      @(negedge CLOCK);
      checkOutput("reset MEM_READ", {31'h0, MEM_READ}, 32'h0);
      checkOutput("reset MEM_ADDRESS", {4'h0, MEM_ADDRESS}, 32'h0);
      checkOutput("reset BUSYWAIT", {31'h0, BUSYWAIT}, 32'h0);
      checkOutput("reset INSTRUCTION", INSTRUCTION, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
      checkOutput("reset HIT_COUNT", HIT_COUNT, 32'h0);
      checkOutput("reset MISS_COUNT", MISS_COUNT, 32'h0);
`endif
      @(posedge CLOCK);
      #1;

      // Cold miss, L=4: 7 stall cycles, 5 MEM_READ cycles.
      applyStimulus(32'h0000_0000, 32'h8F108093, 1'b1, 4);
      // Same-line hits back to back.
      applyStimulus(32'h0000_0004, 32'h00208113, 1'b0, 0);
      applyStimulus(32'h0000_0008, 32'h00310193, 1'b0, 0);
      applyStimulus(32'h0000_000C, 32'h00418213, 1'b0, 0);
`ifdef ICACHE_PERF_CNT_EN
      // The resumed fetch after the fill is itself an IDLE hit, plus 3 more.
      checkOutput("HIT_COUNT after hits", HIT_COUNT, 32'd4);
      checkOutput("MISS_COUNT after hits", MISS_COUNT, 32'd1);
`endif

      // Conflict eviction on index 0.
      applyStimulus(32'h0000_0080, 32'h0AA00093, 1'b1, 2);
      applyStimulus(32'h0000_0084, 32'h0BB00113, 1'b0, 0);
      applyStimulus(32'h0000_0000, 32'h8F108093, 1'b1, 1);

      // Reset in cycle 2 of a miss to 0x010: the fill is abandoned.
      memLatency = 4;
      expAddrQ.push_back(28'h0000001);
      READ    = 1'b1;
      ADDRESS = 32'h0000_0010;
      @(posedge CLOCK); #1;
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      READ  = 1'b0;
      @(negedge CLOCK);
      checkOutput("mid-miss reset MEM_READ", {31'h0, MEM_READ}, 32'h0);
      checkOutput("mid-miss reset BUSYWAIT", {31'h0, BUSYWAIT}, 32'h0);
      @(posedge CLOCK); #1;
      // Line stays invalid, so this misses again.
      applyStimulus(32'h0000_0010, 32'h10000001, 1'b1, 3);
      applyStimulus(32'h0000_001C, 32'h10000004, 1'b0, 0);

      // Zero-latency memory: 3 stall cycles.
      applyStimulus(32'h0000_01F0, 32'h1F0F0001, 1'b1, 0);
      applyStimulus(32'h0000_01F4, 32'h1F0F0002, 1'b0, 0);

      // Idle: no requests, nothing happens.
      begin
`ifdef ICACHE_PERF_CNT_EN
         logic [31:0] hitBefore;
         logic [31:0] missBefore;
         hitBefore  = HIT_COUNT;
         missBefore = MISS_COUNT;
`endif
         READ = 1'b0;
         for (int i = 0; i < 10; i++) begin
            ADDRESS = $urandom;
            @(negedge CLOCK);
            checkOutput("idle BUSYWAIT", {31'h0, BUSYWAIT}, 32'h0);
            checkOutput("idle MEM_READ", {31'h0, MEM_READ}, 32'h0);
            checkOutput("idle INSTRUCTION", INSTRUCTION, 32'h0);
            @(posedge CLOCK); #1;
         end
`ifdef ICACHE_PERF_CNT_EN
         checkOutput("idle HIT_COUNT", HIT_COUNT, hitBefore);
         checkOutput("idle MISS_COUNT", MISS_COUNT, missBefore);
`endif
      end

      checkOutput("instruction queue drained", 32'(expInstrQ.size()), 32'd0);
      checkOutput("address queue drained", 32'(expAddrQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
